i2s_frame_serializer: RTL and testbench
=======================================

Name: i2s_frame_serializer

Overview:
- Drives the audio frame timing for the player stage and serializes its output to the I2S DAC.
- Owns the 8-bit per-frame mclk counter (mclk = 256 x fs) and exports it as m_sample_index for the player.
- Latches p_sample_buffer / valid once per frame.
- Emits BCLK (mclk/4), LRCLK (fs) and SDATA in Philips I2S format. The mono sample is sent on both channels.

Parameters:
SAMPLE_BITS, 16, sample width; legal range 1..31.
UNDERRUN_BITS, 16, width of the saturating underrun counter.

Ports:
mclk  input  1  master clock, 256 x sample rate
rst  input  1  asynchronous, active-low reset
m_sample_index  output  8  frame position counter, to player
p_sample_buffer  input  SAMPLE_BITS  sample from player, two's complement
valid  input  1  player sample valid
mute  input  1  force zero sample for the next frame
underrun_clr  input  1  synchronous clear of underrun_count
frame_tick  output  1  high while m_sample_index == 0
bclk  output  1  I2S bit clock
lrclk  output  1  I2S word select; 0 = left, 1 = right
sdata  output  1  I2S serial data
underrun_count  output  UNDERRUN_BITS  frames latched with valid low, saturating

Behaviour:
- Reset (rst low, asynchronous): m_sample_index=0, frame_tick=1, bclk=0, lrclk=0, sdata=0, hold register=0, underrun_count=0.
- Reset release: the first counter increment occurs on the first mclk rising edge with rst high.
- Counter: i = m_sample_index increments by 1 every mclk and wraps 255 -> 0.
- Output alignment: every output is a flop output. In any cycle where m_sample_index=i:
  - bclk = i[1]; falling edges occur at i%4 == 0.
  - lrclk = i[7].
  - frame_tick = (i == 0).
  - sdata = bit(i), defined below.
- No output may glitch. Each output is computed from the next counter value and registered.
- Bit selection, with slot k = i[6:2] (0..31 within a channel half):
  - k = 0: sdata = 0. This is the one-BCLK I2S delay after an LRCLK change.
  - 1 <= k <= SAMPLE_BITS: sdata = word[SAMPLE_BITS-k]; MSB first.
  - k > SAMPLE_BITS: sdata = 0.
  - sdata is therefore constant for 4 mclk, changing only on bclk falling edges.
- Word for a half: the hold register. Left and right carry the identical word.
- Latch, on the mclk edge where m_sample_index goes 255 -> 0:
  - hold <= 0 if mute=1.
  - Else hold <= p_sample_buffer if valid=1.
  - Else hold <= 0.
  - The player sees index 255 for one full cycle, so p_sample_buffer/valid must be stable at that edge. Values at all other edges are ignored.
  - The latched word is transmitted in the frame that starts at index 0.
- Underrun:
  - On the same latch edge, if valid=0 and mute=0, underrun_count increments, saturating at all-ones. Mute frames never count.
  - underrun_clr=1 at a clock edge sets the count to 0. If clear and increment coincide, clear wins and the result is 0.
- Reset mid-frame: all state returns to reset values immediately; the partially sent word is abandoned. After release, the frame restarts at index 0 with hold=0, so the first frame sends zeros.
- Latency: a sample latched at edge E appears with its left MSB on sdata at m_sample_index=4..7 and its right MSB at m_sample_index=132..135 of the same frame.

Test Plan:
- Reset released, 256 mclk observed:
  - m_sample_index runs 0..255 and wraps.
  - bclk toggles every 2 mclk (64 periods per frame).
  - lrclk is 0 for indices 0..127 and 1 for 128..255.
  - frame_tick is high only at 0.
  - sdata stays 0 for the whole first frame.
- p_sample_buffer=16'hA5F0, valid=1 across the 255->0 edge:
  - Next frame, sampling sdata on bclk rising edges gives 0, then 1010_0101_1111_0000, then 15 zeros, per channel.
  - Left and right are identical.
- valid=0 at the latch for 3 consecutive frames: sdata is all zeros for those frames and underrun_count = 3.
- mute=1 with valid=1, sample 16'h7FFF: the frame is all zeros and underrun_count is unchanged.
- UNDERRUN_BITS=2, 5 underrun frames: count goes 1, 2, 3 and then holds at 3.
  - underrun_clr asserted together with a 6th underrun gives count = 0.
- rst asserted at m_sample_index=70 while sending 16'hFFFF:
  - All outputs go to reset values asynchronously.
  - After release, the frame starts at index 0 with zeros, and the next valid sample serializes correctly.

Source files
------------

// File: rtl/i2s_frame_serializer.sv
`default_nettype none
// i2s_frame_serializer: mclk frame counter, per-frame sample latch and Philips I2S serializer.
// Revision 1.0 - initial release.

module i2s_frame_serializer #(
  parameter int SAMPLE_BITS   = 16,
  parameter int UNDERRUN_BITS = 16
) (
  input  logic                     mclk,
  input  logic                     rst,
  output logic [7:0]               m_sample_index,
  input  logic [SAMPLE_BITS-1:0]   p_sample_buffer,
  input  logic                     valid,
  input  logic                     mute,
  input  logic                     underrun_clr,
  output logic                     frame_tick,
  output logic                     bclk,
  output logic                     lrclk,
  output logic                     sdata,
  output logic [UNDERRUN_BITS-1:0] underrun_count
);

  localparam logic [4:0]               c_SB     = 5'(SAMPLE_BITS);
  localparam logic [UNDERRUN_BITS-1:0] c_UR_MAX = '1;
  localparam logic [UNDERRUN_BITS-1:0] c_UR_ONE = UNDERRUN_BITS'(1);

  logic [7:0]               r_idx;
  logic                     r_tick;
  logic                     r_bclk;
  logic                     r_lrclk;
  logic                     r_sdata;
  logic [SAMPLE_BITS-1:0]   r_hold;
  logic [UNDERRUN_BITS-1:0] r_underrun;

  logic [7:0]  w_idx_nxt;
  logic        w_latch;
  logic [4:0]  w_slot;
  logic        w_in_word;
  logic [4:0]  w_bit_pos;
  logic [31:0] w_hold32;
  logic        w_sdata_nxt;

  // Every output is derived from the next counter value so each is a clean flop output.
  assign w_idx_nxt   = r_idx + 8'd1;
  assign w_latch     = (r_idx == 8'hFF);
  assign w_slot      = w_idx_nxt[6:2];
  assign w_in_word   = (w_slot != 5'd0) && (w_slot <= c_SB);
  assign w_bit_pos   = c_SB - w_slot;
  assign w_hold32    = {{(32-SAMPLE_BITS){1'b0}}, r_hold};
  assign w_sdata_nxt = w_in_word & w_hold32[w_bit_pos];

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      r_idx   <= 8'd0;
      r_tick  <= 1'b1;
      r_bclk  <= 1'b0;
      r_lrclk <= 1'b0;
      r_sdata <= 1'b0;
    end else begin
      r_idx   <= w_idx_nxt;
      r_tick  <= (w_idx_nxt == 8'd0);
      r_bclk  <= w_idx_nxt[1];
      r_lrclk <= w_idx_nxt[7];
      r_sdata <= w_sdata_nxt;
    end
  end

  // The hold register only changes on the wrap edge, so slot 0 of the new frame hides the update.
  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      r_hold <= '0;
    end else if (w_latch) begin
      r_hold <= (mute || !valid) ? '0 : p_sample_buffer;
    end
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      r_underrun <= '0;
    end else if (underrun_clr) begin
      r_underrun <= '0;
    end else if (w_latch && !valid && !mute && (r_underrun != c_UR_MAX)) begin
      r_underrun <= r_underrun + c_UR_ONE;
    end
  end

  assign m_sample_index = r_idx;
  assign frame_tick     = r_tick;
  assign bclk           = r_bclk;
  assign lrclk          = r_lrclk;
  assign sdata          = r_sdata;
  assign underrun_count = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_i2s_frame_serializer.sv
`default_nettype none
// tb_i2s_frame_serializer: scoreboard bench for the I2S frame serializer (default and 2-bit underrun counter).
// Revision 1.0 - initial release.

module tb_i2s_frame_serializer;

  logic        mclk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] p_sample_buffer = 16'h0;
  logic        valid = 1'b0;
  logic        mute = 1'b0;
  logic        underrun_clr = 1'b0;

  logic [7:0]  idx, idx2;
  logic        ftick, bclk, lrclk, sdata;
  logic        ftick2, bclk2, lrclk2, sdata2;
  logic [15:0] ucnt;
  logic [1:0]  ucnt2;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [15:0] word;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_cnt  = 16'h0;
  logic [1:0]  m_cnt2 = 2'h0;

  i2s_frame_serializer #(.SAMPLE_BITS(16), .UNDERRUN_BITS(16)) dut (
    .mclk(mclk), .rst(rst), .m_sample_index(idx), .p_sample_buffer(p_sample_buffer),
    .valid(valid), .mute(mute), .underrun_clr(underrun_clr), .frame_tick(ftick),
    .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .underrun_count(ucnt)
  );

  i2s_frame_serializer #(.SAMPLE_BITS(16), .UNDERRUN_BITS(2)) dut2 (
    .mclk(mclk), .rst(rst), .m_sample_index(idx2), .p_sample_buffer(p_sample_buffer),
    .valid(valid), .mute(mute), .underrun_clr(underrun_clr), .frame_tick(ftick2),
    .bclk(bclk2), .lrclk(lrclk2), .sdata(sdata2), .underrun_count(ucnt2)
  );

  always #5 mclk = ~mclk;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  // Inputs outside the wrap edge must be ignored, so they carry noise.
  task automatic advance(input int n);
    repeat (n) begin
      p_sample_buffer = 16'($urandom);
      valid           = 1'($urandom);
      mute            = 1'($urandom);
      tick();
    end
  endtask

  task automatic latch(input logic [15:0] s, input logic v, input logic m, input logic c);
    exp_t e;
    checks++;
    if (idx !== 8'hFF) begin
      errors++;
      $display("FAIL latch_align: index %0d, required 255", idx);
    end
    p_sample_buffer = s;
    valid           = v;
    mute            = m;
    underrun_clr    = c;
    if (c) begin
      m_cnt  = 16'h0;
      m_cnt2 = 2'h0;
    end else if (!v && !m) begin
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
      if (m_cnt2 != 2'h3) m_cnt2 = m_cnt2 + 2'h1;
    end
    e.word = (m || !v) ? 16'h0 : s;
    e.cnt  = m_cnt;
    e.cnt2 = m_cnt2;
    sb.push_back(e);
    tick();
    underrun_clr = 1'b0;
  endtask

  // Scoreboard consumer: rebuilds each channel word from sdata at bclk rising edges.
  task automatic monitor();
    exp_t        cur;
    logic [31:0] lb, rb, ew;
    logic [4:0]  k;
    bit          in_frame = 1'b0;
    lb = '0;
    rb = '0;
    forever begin
      @(negedge mclk);
      if (!rst || !mon_en) begin
        in_frame = 1'b0;
      end else begin
        if (idx == 8'd0) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            in_frame = 1'b0;
            $display("FAIL sb_empty: frame started with no expected sample queued");
          end else begin
            cur      = sb.pop_front();
            in_frame = 1'b1;
            lb       = '0;
            rb       = '0;
            checks++;
            if (ucnt !== cur.cnt) begin
              errors++;
              $display("FAIL underrun_count: got %0d, required %0d", ucnt, cur.cnt);
            end
            checks++;
            if (ucnt2 !== cur.cnt2) begin
              errors++;
              $display("FAIL underrun_count_2bit: got %0d, required %0d", ucnt2, cur.cnt2);
            end
          end
        end
        if (in_frame && idx[1:0] == 2'd2) begin
          k = idx[6:2];
          if (idx[7]) rb[5'd31 - k] = sdata;
          else        lb[5'd31 - k] = sdata;
        end
        if (in_frame && idx == 8'hFF) begin
          ew = {1'b0, cur.word, 15'h0};
          checks++;
          if (lb !== ew) begin
            errors++;
            $display("FAIL left_word: got %h, required %h", lb, ew);
          end
          checks++;
          if (rb !== ew) begin
            errors++;
            $display("FAIL right_word: got %h, required %h", rb, ew);
          end
          in_frame = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0]  cc;
    logic [11:0] expv;
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (idx !== 8'd0)   begin errors++; $display("FAIL rst_index: got %0d, required 0", idx); end
    checks++; if (ftick !== 1'b1) begin errors++; $display("FAIL rst_frame_tick: got %b, required 1", ftick); end
    checks++; if (bclk !== 1'b0)  begin errors++; $display("FAIL rst_bclk: got %b, required 0", bclk); end
    checks++; if (lrclk !== 1'b0) begin errors++; $display("FAIL rst_lrclk: got %b, required 0", lrclk); end
    checks++; if (sdata !== 1'b0) begin errors++; $display("FAIL rst_sdata: got %b, required 0", sdata); end
    checks++; if (ucnt !== 16'd0) begin errors++; $display("FAIL rst_underrun: got %0d, required 0", ucnt); end
    checks++;
    if ({idx2, bclk2, lrclk2, ftick2, sdata2, ucnt2} !== 14'b0000_0000_0010_00) begin
      errors++;
      $display("FAIL rst_dut2: got %b, required 00000000001000", {idx2, bclk2, lrclk2, ftick2, sdata2, ucnt2});
    end
    rst    = 1'b1;
    m_cnt  = 16'h0;
    m_cnt2 = 2'h0;
    sb.push_back('{word: 16'h0, cnt: 16'h0, cnt2: 2'h0});
    mon_en = 1'b1;
    for (int c = 0; c < 256; c++) begin
      cc   = 8'(c);
      expv = {cc, cc[1], cc[7], (cc == 8'd0), 1'b0};
      checks++;
      if ({idx, bclk, lrclk, ftick, sdata} !== expv) begin
        errors++;
        $display("FAIL frame_timing: idx/bclk/lrclk/tick/sdata got %b, required %b", {idx, bclk, lrclk, ftick, sdata}, expv);
      end
      checks++;
      if ({idx2, bclk2, lrclk2, ftick2, sdata2} !== expv) begin
        errors++;
        $display("FAIL frame_timing_2: got %b, required %b", {idx2, bclk2, lrclk2, ftick2, sdata2}, expv);
      end
      if (c != 255) tick();
    end
  endtask

  task automatic test_sample();
    latch(16'hA5F0, 1'b1, 1'b0, 1'b0);
    advance(255);
    latch(16'h8001, 1'b1, 1'b0, 1'b0);
    advance(255);
    latch(16'($urandom), 1'b1, 1'b0, 1'b0);
    advance(255);
  endtask

  task automatic test_underrun();
    repeat (3) begin
      latch(16'($urandom), 1'b0, 1'b0, 1'b0);
      advance(255);
    end
    checks++; if (ucnt !== 16'd3) begin errors++; $display("FAIL underrun_three: got %0d, required 3", ucnt); end
    checks++; if (ucnt2 !== 2'd3) begin errors++; $display("FAIL underrun_three_2bit: got %0d, required 3", ucnt2); end
  endtask

  task automatic test_mute();
    latch(16'h7FFF, 1'b1, 1'b1, 1'b0);
    advance(255);
    checks++; if (ucnt !== 16'd3) begin errors++; $display("FAIL mute_valid_count: got %0d, required 3", ucnt); end
    latch(16'h1234, 1'b0, 1'b1, 1'b0);
    advance(255);
    checks++; if (ucnt !== 16'd3) begin errors++; $display("FAIL mute_invalid_count: got %0d, required 3", ucnt); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp2 [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    latch(16'($urandom), 1'b1, 1'b0, 1'b1);
    checks++; if (ucnt !== 16'd0) begin errors++; $display("FAIL clear_count: got %0d, required 0", ucnt); end
    checks++; if (ucnt2 !== 2'd0) begin errors++; $display("FAIL clear_count_2bit: got %0d, required 0", ucnt2); end
    advance(255);
    for (int i = 0; i < 5; i++) begin
      latch(16'($urandom), 1'b0, 1'b0, 1'b0);
      checks++;
      if (ucnt2 !== exp2[i]) begin
        errors++;
        $display("FAIL saturate_step%0d: got %0d, required %0d", i, ucnt2, exp2[i]);
      end
      checks++;
      if (ucnt !== 16'(i + 1)) begin
        errors++;
        $display("FAIL wide_step%0d: got %0d, required %0d", i, ucnt, i + 1);
      end
      advance(255);
    end
    latch(16'($urandom), 1'b0, 1'b0, 1'b1);
    checks++; if (ucnt2 !== 2'd0) begin errors++; $display("FAIL clear_wins_2bit: got %0d, required 0", ucnt2); end
    checks++; if (ucnt !== 16'd0) begin errors++; $display("FAIL clear_wins: got %0d, required 0", ucnt); end
    advance(255);
  endtask

  task automatic test_reset_midframe();
    latch(16'h0000, 1'b0, 1'b0, 1'b0);
    advance(255);
    latch(16'hFFFF, 1'b1, 1'b0, 1'b0);
    advance(70);
    checks++;
    if ({idx, bclk} !== {8'd70, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset_pos: idx/bclk got %b, required %b", {idx, bclk}, {8'd70, 1'b1});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({idx, ftick, bclk, lrclk, sdata} !== {8'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: idx/tick/bclk/lrclk/sdata got %b, required 000000001000", {idx, ftick, bclk, lrclk, sdata});
    end
    checks++; if (ucnt !== 16'd0) begin errors++; $display("FAIL async_reset_count: got %0d, required 0", ucnt); end
    sb.delete();
    m_cnt  = 16'h0;
    m_cnt2 = 2'h0;
    repeat (2) tick();
    checks++; if (idx !== 8'd0) begin errors++; $display("FAIL reset_hold_index: got %0d, required 0", idx); end
    rst = 1'b1;
    sb.push_back('{word: 16'h0, cnt: 16'h0, cnt2: 2'h0});
    advance(255);
    latch(16'hC3A5, 1'b1, 1'b0, 1'b0);
    advance(255);
    latch(16'($urandom), 1'b1, 1'b0, 1'b0);
    advance(255);
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_sample();
    test_underrun();
    test_mute();
    test_saturation();
    test_reset_midframe();
    @(negedge mclk);
    #1;
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
